video_timing_gen: RTL

Pixel-timing and test-pattern source that feeds the TMDS encoder. It produces de/pixel pairs plus hsync, vsync and start-of-frame for a parameterised raster, 640x480@60 by default. It advances one pixel per rdy_i strobe, the same strobe the encoder and serializer use, so it stays pixel-aligned with the encoder's symbol register. Outputs are registered and fed straight into the encoder's de_i/d_i inputs.

---
 rtl/video_timing_gen.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// Raster timing and 1-bit test-pattern source for the TMDS encoder.
// Advances one pixel per rdy_i strobe; all outputs are registered decodes of the pixel counters.
module video_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int CHECK_LOG2 = 5,
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW        = $clog2(H_TOTAL),
    localparam int VW        = $clog2(V_TOTAL)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          rdy_i,
    input  logic [1:0]    pat_i,
    output logic          de_o,
    output logic          d_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          sof_o,
    output logic [HW-1:0] x_o,
    output logic [VW-1:0] y_o,
    output logic [15:0]   frame_o
);

    if (H_TOTAL < 2 || V_TOTAL < 2 || H_ACTIVE < 1 || V_ACTIVE < 1 ||
        H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        CHECK_LOG2 < 0 || CHECK_LOG2 >= HW || CHECK_LOG2 >= VW) begin : g_bad_params
        $error("video_timing_gen: invalid timing parameters");
    end

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [1:0]    pat_q, pat_d;
    logic [15:0]   frame_q, frame_d;
    logic          de_q, de_d;
    logic          d_q, d_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          sof_q, sof_d;
    logic [HW-1:0] x_q, x_d;
    logic [VW-1:0] y_q, y_d;

    logic          at_origin;
    logic          active;
    logic          border;
    logic          pixel;
    logic [1:0]    pat_sel;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        pat_d   = pat_q;
        frame_d = frame_q;
        de_d    = de_q;
        d_d     = d_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        sof_d   = sof_q;
        x_d     = x_q;
        y_d     = y_q;

        at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
        active    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        border    = (h_cnt_q == '0) || (h_cnt_q == H_ACT_LAST) ||
                    (v_cnt_q == '0) || (v_cnt_q == V_ACT_LAST);
        // The first pixel of a frame already uses the pattern being latched for that frame.
        pat_sel   = at_origin ? pat_i : pat_q;

        case (pat_sel)
            2'd0:    pixel = 1'b0;
            2'd1:    pixel = 1'b1;
            2'd2:    pixel = h_cnt_q[CHECK_LOG2] ^ v_cnt_q[CHECK_LOG2];
            default: pixel = border;
        endcase

        if (rdy_i) begin
            de_d    = active;
            d_d     = active & pixel;
            hsync_d = (h_cnt_q >= HS_START && h_cnt_q < HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync_d = (v_cnt_q >= VS_START && v_cnt_q < VS_END) ? SYNC_POL : ~SYNC_POL;
            sof_d   = at_origin;
            x_d     = h_cnt_q;
            y_d     = v_cnt_q;

            if (at_origin) begin
                pat_d   = pat_i;
                frame_d = frame_q + 16'd1;
            end

            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
            end else begin
                h_cnt_d = h_cnt_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            pat_q   <= '0;
            frame_q <= '0;
            de_q    <= 1'b0;
            d_q     <= 1'b0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            sof_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            pat_q   <= pat_d;
            frame_q <= frame_d;
            de_q    <= de_d;
            d_q     <= d_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            sof_q   <= sof_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign de_o    = de_q;
    assign d_o     = d_q;
    assign hsync_o = hsync_q;
    assign vsync_o = vsync_q;
    assign sof_o   = sof_q;
    assign x_o     = x_q;
    assign y_o     = y_q;
    assign frame_o = frame_q;

endmodule
